status_emitter: RTL and testbench

- Parametrised successor to the combinational status-word encoder.
- Accepts a stream of per-operation outcomes (success/failure) from the mode controller and buffers them in a DEPTH-entry FIFO.
- Emits each outcome as a BUS_W-bit status word on a valid/ready output port toward the I/O interface.
- Keeps saturating success/failure counters and a sticky failure flag, readable by the control logic.

---
 rtl/status_emitter.sv | 117 +++++++++++
 tb/tb_status_emitter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/status_emitter.sv
// status_emitter
//   Buffers per-operation outcomes from the mode controller in a DEPTH-entry
//   FIFO. Each buffered outcome is emitted as a BUS_W-bit status word on a
//   valid/ready port. Saturating outcome counters and a sticky failure flag
//   are kept for the control logic.
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   st_valid/st_fail     outcome input (1 = FAILURE, 0 = SUCCESS)
//   st_ready             FIFO has room for an outcome
//   dout/dout_valid      status word at the FIFO head (zero when not valid)
//   dout_ready           consumer accepts dout
//   clr                  synchronous clear of the counters and sticky flag
//   fail_seen            a FAILURE was accepted since reset/clr
//   n_success/n_failure  saturating counts of accepted outcomes
//   level                FIFO occupancy
module status_emitter #(
  parameter int BUS_W = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic                       st_fail,
  output logic                       st_ready,
  output logic [BUS_W-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  input  logic                       clr,
  output logic                       fail_seen,
  output logic [CNT_W-1:0]           n_success,
  output logic [CNT_W-1:0]           n_failure,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (BUS_W < 4) begin : g_bad_bus
    $error("status_emitter: BUS_W must be >= 4");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("status_emitter: DEPTH must be a power of two >= 2");
  end

  // One bit per entry is enough: the word is rebuilt from the outcome at the head.
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] ns_q, ns_d, nf_q, nf_d;
  logic             fs_q, fs_d;
  logic             push, pop;

  // Handshake qualifiers come from registered occupancy only, so a pop in the
  // same cycle never opens room for a push into a full FIFO.
  assign st_ready   = (level_q != LW'(DEPTH));
  assign dout_valid = (level_q != '0);
  assign push       = st_valid && st_ready;
  assign pop        = dout_valid && dout_ready;

  assign dout = dout_valid ? {3'b111, mem_q[rd_q], {(BUS_W-4){1'b0}}} : '0;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // clr takes priority over a push for the statistics only.
  always_comb begin
    ns_d = ns_q;
    nf_d = nf_q;
    fs_d = fs_q;
    if (clr) begin
      ns_d = '0;
      nf_d = '0;
      fs_d = 1'b0;
    end else if (push) begin
      if (st_fail) begin
        fs_d = 1'b1;
        if (nf_q != CNT_MAX) nf_d = nf_q + 1'b1;
      end else if (ns_q != CNT_MAX) begin
        ns_d = ns_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ns_q    <= '0;
      nf_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= st_fail;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      ns_q    <= ns_d;
      nf_q    <= nf_d;
      fs_q    <= fs_d;
    end
  end

  assign level     = level_q;
  assign n_success = ns_q;
  assign n_failure = nf_q;
  assign fail_seen = fs_q;
endmodule

// File: tb/tb_status_emitter.sv
module tb_status_emitter;
  logic clk = 1'b0;
  logic rst, st_valid, st_fail, dout_ready, clr;
  always #5 clk = ~clk;

  // Default build
  logic        st_ready_a, dv_a, fs_a;
  logic [31:0] dout_a;
  logic [7:0]  ns_a, nf_a;
  logic [2:0]  lvl_a;
  // CNT_W=3 build
  logic        st_ready_b, dv_b, fs_b;
  logic [31:0] dout_b;
  logic [2:0]  ns_b, nf_b;
  logic [2:0]  lvl_b;
  // BUS_W=64 build
  logic        st_ready_c, dv_c, fs_c;
  logic [63:0] dout_c;
  logic [7:0]  ns_c, nf_c;
  logic [2:0]  lvl_c;

  status_emitter u_a (.clk(clk), .rst(rst), .st_valid(st_valid), .st_fail(st_fail),
    .st_ready(st_ready_a), .dout(dout_a), .dout_valid(dv_a), .dout_ready(dout_ready),
    .clr(clr), .fail_seen(fs_a), .n_success(ns_a), .n_failure(nf_a), .level(lvl_a));
  status_emitter #(.CNT_W(3)) u_b (.clk(clk), .rst(rst), .st_valid(st_valid),
    .st_fail(st_fail), .st_ready(st_ready_b), .dout(dout_b), .dout_valid(dv_b),
    .dout_ready(dout_ready), .clr(clr), .fail_seen(fs_b), .n_success(ns_b),
    .n_failure(nf_b), .level(lvl_b));
  status_emitter #(.BUS_W(64)) u_c (.clk(clk), .rst(rst), .st_valid(st_valid),
    .st_fail(st_fail), .st_ready(st_ready_c), .dout(dout_c), .dout_valid(dv_c),
    .dout_ready(dout_ready), .clr(clr), .fail_seen(fs_c), .n_success(ns_c),
    .n_failure(nf_c), .level(lvl_c));

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  typedef struct {
    logic       v, f, r, c;
    logic [3:0] nib;   // expected top nibble, 0 when nothing valid
    logic [2:0] lvl;
    logic       rdy;
    int         ns, nf;
    logic       fs;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic f, logic r, logic c);
    st_valid = v; st_fail = f; dout_ready = r; clr = c;
  endtask

  initial begin
    // inputs, then expected outputs after the edge
    tbl[0]  = '{1,0,0,0, 4'hE,3'd1,1, 1,0,0};
    tbl[1]  = '{1,1,0,0, 4'hE,3'd2,1, 1,1,1};
    tbl[2]  = '{1,1,0,0, 4'hE,3'd3,1, 1,2,1};
    tbl[3]  = '{1,0,0,0, 4'hE,3'd4,0, 2,2,1};
    tbl[4]  = '{1,1,0,0, 4'hE,3'd4,0, 2,2,1};  // ignored: FIFO full
    tbl[5]  = '{0,0,1,0, 4'hF,3'd3,1, 2,2,1};
    tbl[6]  = '{0,0,1,0, 4'hF,3'd2,1, 2,2,1};
    tbl[7]  = '{0,0,1,0, 4'hE,3'd1,1, 2,2,1};
    tbl[8]  = '{0,0,1,0, 4'h0,3'd0,1, 2,2,1};
    tbl[9]  = '{0,0,1,1, 4'h0,3'd0,1, 0,0,0};
    tbl[10] = '{1,1,1,0, 4'hF,3'd1,1, 0,1,1};  // push into empty: no pop yet
    tbl[11] = '{0,0,1,0, 4'h0,3'd0,1, 0,1,1};  // popped after one cycle, flag sticks
    tbl[12] = '{1,0,0,1, 4'hE,3'd1,1, 0,0,0};  // clr wins, word still enters
    tbl[13] = '{1,1,1,0, 4'hF,3'd1,1, 0,1,1};  // push + pop together

    drive(0,0,0,0);
    rst = 1'b1;
    #12;
    chk("rst_dv", dv_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_rdy", st_ready_a, 1);
    chk("rst_lvl", lvl_a, 0);
    chk("rst_cnt", {fs_a, ns_a, nf_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].c);
      tick();
      chk($sformatf("v%0d_dout", i), dout_a, {32'h0, tbl[i].nib, 28'h0});
      chk($sformatf("v%0d_dout64", i), dout_c, {tbl[i].nib, 60'h0});
      chk($sformatf("v%0d_dv", i), dv_a, tbl[i].nib != 0);
      chk($sformatf("v%0d_lvl", i), lvl_a, tbl[i].lvl);
      chk($sformatf("v%0d_rdy", i), st_ready_a, tbl[i].rdy);
      chk($sformatf("v%0d_ns", i), ns_a, tbl[i].ns);
      chk($sformatf("v%0d_nf", i), nf_a, tbl[i].nf);
      chk($sformatf("v%0d_fs", i), fs_a, tbl[i].fs);
    end

    // Drain, then stream alternating outcomes with push and pop every cycle.
    drive(0,0,1,0);
    tick();
    chk("drain_lvl", lvl_a, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, i[0], 1, 0);
      tick();
      chk($sformatf("str%0d_lvl", i), lvl_a, 1);
      chk($sformatf("str%0d_dout", i), dout_a, i[0] ? 32'hF000_0000 : 32'hE000_0000);
    end
    drive(0,0,1,0);
    tick();
    chk("str_end_lvl", lvl_a, 0);

    // Saturation on the narrow-counter build, then clr racing a FAILURE push.
    drive(0,0,1,1);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1,0,1,0);
      tick();
    end
    chk("sat_ns3", ns_b, 7);
    chk("sat_ns8", ns_a, 9);
    drive(1,1,1,1);
    tick();
    chk("clr_nf", nf_b, 0);
    chk("clr_fs", fs_b, 0);
    chk("clr_ns", ns_b, 0);
    // FAILURE is at the head now (previous SUCCESS popped on the same edge)
    chk("clr_dout", dout_b, 32'hF000_0000);
    drive(0,0,1,0);
    tick();
    chk("clr_empty", dv_b, 0);

    // Asynchronous reset with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      drive(1,1,0,0);
      tick();
    end
    chk("pre_rst_lvl", lvl_a, 3);
    chk("pre_rst_dv", dv_a, 1);
    drive(0,0,0,0);
    #2 rst = 1'b1;
    #1;
    chk("arst_dv", dv_a, 0);
    chk("arst_dout", dout_a, 0);
    chk("arst_dout64", dout_c, 0);
    chk("arst_lvl", lvl_a, 0);
    chk("arst_cnt", {fs_a, ns_a, nf_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1,0,0,0);
    tick();
    chk("post_rst_dout", dout_a, 32'hE000_0000);
    chk("post_rst_ns", ns_a, 1);
    drive(1,1,1,0);
    tick();
    drive(0,0,1,0);
    chk("post_rst_64", dout_c, 64'hF000_0000_0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
